// File: rtl/asr_sequencer_pkg.sv
// Shared types and default sizing for the arithmetic-right-shift sequencer.
package asr_sequencer_pkg;

  localparam int unsigned DEF_WIDTH = 4;
  localparam int unsigned DEF_AMT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/asr_step.sv
// Combinational sign-extending shift stage: by 2 when by2 is set, else by 1.
module asr_step #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] x,
  input  logic             by2,
  output logic [WIDTH-1:0] y_c
);

  always_comb begin
    y_c = by2 ? WIDTH'($signed(x) >>> 2) : WIDTH'($signed(x) >>> 1);
  end

endmodule

// File: rtl/asr_sequencer.sv
// Sequences a single asr_step stage to arithmetic-shift a word right by an arbitrary amount.
module asr_sequencer
  import asr_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned AMT_W = DEF_AMT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] sig_in,
  input  logic [AMT_W-1:0] amount,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sig_out
);

  state_e           state;
  logic [WIDTH-1:0] acc;
  logic [AMT_W-1:0] cnt;
  logic             by2;
  logic [WIDTH-1:0] step_y;

  assign by2 = (cnt > AMT_W'(1));

  asr_step #(.WIDTH(WIDTH)) u_step (
    .x   (acc),
    .by2 (by2),
    .y_c (step_y)
  );

  // busy/done are registered alongside the state they decode from.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      acc     <= '0;
      cnt     <= '0;
      sig_out <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          busy <= 1'b0;
          if (start) begin
            acc   <= sig_in;
            cnt   <= amount;
            state <= ST_SHIFT;
            busy  <= 1'b1;
          end
        end
        ST_SHIFT: begin
          busy <= 1'b1;
          if (cnt != '0) begin
            acc <= step_y;
            cnt <= by2 ? cnt - AMT_W'(2) : '0;
          end else begin
            sig_out <= acc;
            state   <= ST_DONE;
            done    <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_asr_sequencer.sv
// Bench for asr_sequencer: operation-level reference model plus directed literal cases.
module tb_asr_sequencer;

  localparam int unsigned W = 4;
  localparam int unsigned A = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] sig_in;
  logic [A-1:0] amount;
  logic         busy;
  logic         done;
  logic [W-1:0] sig_out;

  int checks = 0;
  int errors = 0;
  int done_pulses = 0;
  bit chk_en = 1'b0;

  // Reference: cycles of busy left in the current operation, its result, and the output register.
  int           m_left = 0;
  logic [W-1:0] m_res = '0;
  logic [W-1:0] m_out = '0;

  always #5 clk = ~clk;

  asr_sequencer #(.WIDTH(W), .AMT_W(A)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .sig_in  (sig_in),
    .amount  (amount),
    .busy    (busy),
    .done    (done),
    .sig_out (sig_out)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // An accepted request keeps busy for ceil(a/2)+2 cycles; done and the result land in the last one.
  always @(posedge clk) begin
    if (rst) begin
      m_left = 0;
      m_out  = '0;
    end else if (m_left == 0) begin
      if (start) begin
        m_res  = W'($signed(sig_in) >>> amount);
        m_left = (int'(amount) + 1) / 2 + 2;
      end
    end else begin
      m_left--;
      if (m_left == 1) m_out = m_res;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(m_left > 0));
      chk("done", 32'(done), 32'(m_left == 1));
      chk("sig_out", 32'(sig_out), 32'(m_out));
      if (done) done_pulses++;
    end
  end

  task automatic run_op(input logic [W-1:0] x, input logic [A-1:0] a,
                        input logic [W-1:0] exp, input int exp_n);
    int n;
    bit seen;
    @(posedge clk); #2;
    start = 1'b1; sig_in = x; amount = a;
    @(posedge clk); #2;
    start = 1'b0;
    n = 1;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else n++;
    end
    chk("op_done_seen", 32'(seen), 32'd1);
    chk("op_latency", 32'(n), 32'(exp_n));
    chk("op_result", 32'(sig_out), 32'(exp));
    @(posedge clk); #2;
  endtask

  initial begin
    int p0;
    rst = 1'b1; start = 1'b1; sig_in = 4'b1111; amount = 3'd3;

    @(posedge clk); #2;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sig_out", 32'(sig_out), 32'd0);
    @(posedge clk); #2;
    @(negedge clk);
    chk("rst2_busy", 32'(busy), 32'd0);
    chk("rst2_sig_out", 32'(sig_out), 32'd0);
    @(posedge clk); #2;
    rst = 1'b0; start = 1'b0;

    run_op(4'b1000, 3'd2, 4'b1110, 3);
    run_op(4'b1011, 3'd3, 4'b1111, 4);
    run_op(4'b0110, 3'd3, 4'b0000, 4);
    run_op(4'b1010, 3'd0, 4'b1010, 2);

    // A second start during the operation must be dropped.
    p0 = done_pulses;
    @(posedge clk); #2;
    start = 1'b1; sig_in = 4'b0111; amount = 3'd7;
    @(posedge clk); #2;
    start = 1'b0;
    @(posedge clk); #2;
    start = 1'b1; sig_in = 4'b1000; amount = 3'd1;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    chk("sat_one_done", 32'(done_pulses - p0), 32'd1);
    chk("sat_result", 32'(sig_out), 32'd0);
    chk("sat_idle", 32'(busy), 32'd0);

    // Reset mid-operation aborts without a done pulse.
    p0 = done_pulses;
    @(posedge clk); #2;
    start = 1'b1; sig_in = 4'b1100; amount = 3'd6;
    @(posedge clk); #2;
    start = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sig_out", 32'(sig_out), 32'd0);
    repeat (5) @(posedge clk);
    #2;
    chk("abort_no_done", 32'(done_pulses - p0), 32'd0);
    run_op(4'b1100, 3'd1, 4'b1110, 3);

    // Random traffic, including held start, mid-op input churn and occasional resets.
    repeat (1500) begin
      @(posedge clk); #2;
      start  = ($urandom_range(0, 3) != 0);
      sig_in = W'($urandom);
      amount = A'($urandom);
      rst    = ($urandom_range(0, 99) == 0);
    end
    @(posedge clk); #2;
    rst = 1'b0; start = 1'b0;
    repeat (10) @(posedge clk);
    #2;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/asr_sequencer.md
# asr_sequencer

Multi-cycle arithmetic-right-shift controller. It accepts a signed word and a shift amount, then repeatedly drives a sign-extending shift-by-2 / shift-by-1 datapath stage until the requested amount is consumed. It returns the result with a one-cycle `done` pulse. It sits in front of the combinational arithmetic-shift datapath and sequences it so that arbitrary shift amounts reuse a single small stage.

## Interface

- `WIDTH`, default 4: data word width in bits, two's complement.
- `AMT_W`, default 3: shift-amount width; amounts 0 to 2^AMT_W−1.
- `clk` input, 1 bit: the single clock; all state updates on the rising edge.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `start` input, 1 bit: request strobe; sampled only in IDLE.
- `sig_in` input, WIDTH bits: operand, captured when `start` is accepted.
- `amount` input, AMT_W bits: shift count, captured when `start` is accepted.
- `busy` output, 1 bit: high while an operation is in progress (SHIFT or DONE).
- `done` output, 1 bit: one-cycle pulse; `sig_out` is valid.
- `sig_out` output, WIDTH bits: result register; holds its value until the next DONE.

## Operation

- **Internal state**
  - `acc` (WIDTH): working word.
  - `cnt` (AMT_W): remaining shift count.
  - `state` ∈ {IDLE, SHIFT, DONE}.
- **Moore machine.** `busy` and `done` decode from `state` only. There is no combinational path from inputs to outputs.
- **IDLE**
  - `busy`=0, `done`=0.
  - If `start`=1: `acc`←`sig_in`, `cnt`←`amount`, go to SHIFT.
  - Otherwise stay in IDLE.
- **SHIFT**
  - `busy`=1. One action per edge, in priority order:
    - `cnt`≥2: `acc`←asr2(`acc`), `cnt`←`cnt`−2, stay in SHIFT.
    - `cnt`=1: `acc`←asr1(`acc`), `cnt`←0, stay in SHIFT.
    - `cnt`=0: `sig_out`←`acc`, go to DONE.
- **DONE:** `busy`=1, `done`=1; unconditionally go to IDLE next edge.
- **Shift arithmetic**
  - asr2(x) = {x[W−1], x[W−1], x[W−1:2]}.
  - asr1(x) = {x[W−1], x[W−1:1]}.
  - Shifting by ≥ WIDTH−1 saturates to all sign bits (0…0 or 1…1). No special case is needed.
- **`start` outside IDLE** (SHIFT or DONE) is ignored. It is not queued. `sig_in`/`amount` changes during an operation have no effect.
- **`start` held high continuously:** a new operation is accepted on the first edge spent in IDLE after DONE. This gives back-to-back throughput of one operation per ceil(a/2)+3 cycles.

## Timing

- **Reset values:** `state`=IDLE, `acc`=0, `cnt`=0, `sig_out`=0, `busy`=0, `done`=0.
- **Reset priority:** `rst` overrides everything, including mid-SHIFT. The operation is aborted, no `done` pulse is produced, and `sig_out` clears to 0.
- **Latency.** Let edge E0 be the edge that samples `start` in IDLE, and k = ceil(a/2) for amount a.
  - Edges E1 through Ek perform the shifts.
  - Edge Ek+1 loads `sig_out` and enters DONE.
  - `done` is high for exactly the cycle following Ek+1.
  - Edge Ek+2 returns to IDLE.
- **Latency examples:** a=0 gives done after E1; a=7 gives done after E5.
- **`busy`** rises after E0 and falls after Ek+2.
- **`sig_out` update timing:** `sig_out` changes only at the edge entering DONE, so it is stable whenever `done`=1.

## Structure

- **Shared package**
  - State encoding: IDLE=2'b00, SHIFT=2'b01, DONE=2'b10; 2'b11 is illegal and recovers to IDLE.
  - Default WIDTH/AMT_W constants.
- **Sub-module `asr_step`:** combinational datapath stage.
  - Inputs: `x[WIDTH-1:0]`, `by2`.
  - Output: asr2(x) when `by2`=1, asr1(x) otherwise.
  - Instantiated once; the sequencer drives `by2` = (`cnt`≥2).
- **Sequencer:** the FSM plus the `acc`/`cnt`/`sig_out` registers.

## Test plan

- **Reset:** hold `rst`=1 for 2 cycles with `start`=1 → `busy`=0, `done`=0, `sig_out`=4'b0000 throughout; no operation starts.
- **Even shift:** `sig_in`=4'b1000, `amount`=2, pulse `start` → `done` after E2 (k=1), `sig_out`=4'b1110, `busy` high for 3 cycles.
- **Odd shift:** `sig_in`=4'b1011, `amount`=3 → intermediate `acc`=4'b1110 after E1, 4'b1111 after E2; `done` after E3; `sig_out`=4'b1111. Repeat with 4'b0110 → `sig_out`=4'b0000.
- **Zero shift:** `sig_in`=4'b1010, `amount`=0 → `done` after E1, `sig_out`=4'b1010.
- **Saturation and ignored start:** `sig_in`=4'b0111, `amount`=7; re-pulse `start` with `sig_in`=4'b1000 at E2 → the second request is ignored; `done` after E5 with `sig_out`=4'b0000; exactly one `done` pulse.
- **Reset mid-operation:** start `sig_in`=4'b1100, `amount`=6, assert `rst` at E2 → IDLE next cycle, `sig_out`=0, no `done`. A fresh request then completes normally: `amount`=1 yields `sig_out`=4'b1110.
